fir_output_sink: RTL and testbench

Receiving end of the FIR filter output stream. Takes the filter's free-running sample/valid pair (no backpressure toward the filter) and scales it with an arithmetic right shift. It saturates the result to the downstream word width, buffers it in a small FIFO, and presents it on a valid/ready interface. Sits between the filter core and any stalling consumer (DAC serializer, bus bridge), and reports overflow and saturation events.

---
 rtl/fir_output_sink.sv | 149 ++++++++++++++
 tb/tb_fir_output_sink.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_output_sink.sv
// FIR output sink: scale (arithmetic shift), saturate, buffer in a FWFT FIFO, present on valid/ready.
// Optional build macro FIR_SINK_ROUND_EN: round half up before the shift instead of truncating.
module fir_output_sink #(
  parameter int DATA_WIDTH = 24,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_en,
  input  logic signed [DATA_WIDTH-1:0]  iv_din,
  input  logic                          i_din_valid,
  output logic signed [OUT_WIDTH-1:0]   ov_dout,
  output logic                          o_dout_valid,
  input  logic                          i_dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   ov_level,
  output logic                          o_sat,
  output logic                          o_overflow,
  input  logic                          i_clr_ovf,
  output logic [15:0]                   ov_drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Saturation bounds expressed in the widened (DATA_WIDTH+1) domain.
  localparam logic signed [DATA_WIDTH:0] SAT_MAX =
    {{(DATA_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH:0] SAT_MIN =
    {{(DATA_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
`ifdef FIR_SINK_ROUND_EN
  // Half an LSB of the shifted result; zero when SHIFT is 0.
  localparam logic signed [DATA_WIDTH:0] RND =
    ({{DATA_WIDTH{1'b0}}, 1'b1} << SHIFT) >> 1;
`endif

  logic signed [DATA_WIDTH:0] din_ext;
  logic signed [DATA_WIDTH:0] din_shr;
  logic signed [OUT_WIDTH-1:0] sat_val;
  logic                        clip;

  logic                        s1_valid;
  logic                        s1_sat;
  logic signed [OUT_WIDTH-1:0] s1_data;

  logic signed [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]                 wr_ptr;
  logic [AW:0]                 rd_ptr;
  logic [AW:0]                 rd_ptr_nxt;
  logic [AW:0]                 level;
  logic                        full;
  logic                        pop;
  logic                        push;
  logic                        drop;
  logic                        head_valid_nxt;

  // NOTE: every signal assigned in always_comb gets a value on every path; a missing default infers a latch.
  always_comb begin
    din_ext = {iv_din[DATA_WIDTH-1], iv_din};
`ifdef FIR_SINK_ROUND_EN
    din_ext = din_ext + RND;
`endif
    din_shr = din_ext >>> SHIFT;
    clip    = 1'b0;
    sat_val = din_shr[OUT_WIDTH-1:0];
    if (din_shr > SAT_MAX) begin
      clip    = 1'b1;
      sat_val = SAT_MAX[OUT_WIDTH-1:0];
    end else if (din_shr < SAT_MIN) begin
      clip    = 1'b1;
      sat_val = SAT_MIN[OUT_WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_sat   <= 1'b0;
      s1_data  <= '0;
    end else if (i_en) begin
      s1_valid <= i_din_valid;
      s1_sat   <= i_din_valid & clip;
      s1_data  <= sat_val;
    end
  end

  assign o_sat = s1_valid & s1_sat;

  // Level counts the head register too, so a full FIFO only accepts a write alongside a pop.
  always_comb begin
    level          = wr_ptr - rd_ptr;
    full           = (level == (AW+1)'(FIFO_DEPTH));
    pop            = o_dout_valid & i_dout_ready;
    push           = s1_valid & (~full | pop);
    drop           = s1_valid & full & ~pop;
    rd_ptr_nxt     = rd_ptr + (AW+1)'(pop);
    // Compared against the pre-write pointer: a word written this edge shows up one cycle later.
    head_valid_nxt = (wr_ptr != rd_ptr_nxt);
  end

  assign ov_level = level;

  // NOTE: the storage array has no reset; pointers define which entries are live, so stale contents are never observed.
  always_ff @(posedge i_clk) begin
    if (i_en && push) begin
      mem[wr_ptr[AW-1:0]] <= s1_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_dout_valid <= 1'b0;
      ov_dout      <= '0;
    end else if (i_en) begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr       <= rd_ptr_nxt;
      o_dout_valid <= head_valid_nxt;
      if (head_valid_nxt) begin
        ov_dout <= mem[rd_ptr_nxt[AW-1:0]];
      end
    end
  end

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow  <= 1'b0;
      ov_drop_cnt <= '0;
    end else if (i_en) begin
      if (drop) begin
        o_overflow <= 1'b1;
        if (i_clr_ovf) begin
          ov_drop_cnt <= 16'd1;
        end else if (ov_drop_cnt != 16'hFFFF) begin
          ov_drop_cnt <= ov_drop_cnt + 16'd1;
        end
      end else if (i_clr_ovf) begin
        o_overflow  <= 1'b0;
        ov_drop_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fir_output_sink.sv
// Directed self-checking bench for fir_output_sink (default parameters, either rounding build).
module tb_fir_output_sink;

  localparam int DW = 24;
  localparam int OW = 16;
  localparam int LW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_en;
  logic [DW-1:0] iv_din;
  logic          i_din_valid;
  logic [OW-1:0] ov_dout;
  logic          o_dout_valid;
  logic          i_dout_ready;
  logic [LW-1:0] ov_level;
  logic          o_sat;
  logic          o_overflow;
  logic          i_clr_ovf;
  logic [15:0]   ov_drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  fir_output_sink #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .SHIFT(4), .FIFO_DEPTH(8)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (i_en),
    .iv_din       (iv_din),
    .i_din_valid  (i_din_valid),
    .ov_dout      (ov_dout),
    .o_dout_valid (o_dout_valid),
    .i_dout_ready (i_dout_ready),
    .ov_level     (ov_level),
    .o_sat        (o_sat),
    .o_overflow   (o_overflow),
    .i_clr_ovf    (i_clr_ovf),
    .ov_drop_cnt  (ov_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  logic [OW-1:0] exp_neg8;
  logic [OW-1:0] exp_pos24;

  initial begin
`ifdef FIR_SINK_ROUND_EN
    exp_neg8  = 16'h0000;
    exp_pos24 = 16'h0002;
`else
    exp_neg8  = 16'hFFFF;
    exp_pos24 = 16'h0001;
`endif
    i_rst_n = 1'b1; i_en = 1'b1; iv_din = '0; i_din_valid = 1'b0;
    i_dout_ready = 1'b0; i_clr_ovf = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(o_dout_valid), 32'd0);
    check("rst_level", 32'(ov_level), 32'd0);
    check("rst_drop", 32'(ov_drop_cnt), 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    // Single sample, two-cycle latency, FIFO drains.
    i_dout_ready = 1'b1;
    iv_din = 24'h001234; i_din_valid = 1'b1;
    tick;
    i_din_valid = 1'b0;
    check("t1_sat", 32'(o_sat), 32'd0);
    check("t1_valid_k", 32'(o_dout_valid), 32'd0);
    tick;
    check("t1_valid_k1", 32'(o_dout_valid), 32'd0);
    check("t1_level_k1", 32'(ov_level), 32'd1);
    tick;
    check("t1_valid_k2", 32'(o_dout_valid), 32'd1);
    check("t1_dout", 32'(ov_dout), 32'h0123);
    tick;
    check("t1_valid_done", 32'(o_dout_valid), 32'd0);
    check("t1_level_done", 32'(ov_level), 32'd0);

    // Positive and negative saturation.
    iv_din = 24'h7FFFFF; i_din_valid = 1'b1;
    tick;
    check("t2_sat_hi", 32'(o_sat), 32'd1);
    iv_din = 24'h800000;
    tick;
    check("t2_sat_lo", 32'(o_sat), 32'd1);
    i_din_valid = 1'b0;
    tick;
    check("t2_sat_off", 32'(o_sat), 32'd0);
    check("t2_dout_max", 32'(ov_dout), 32'h7FFF);
    tick;
    check("t2_dout_min", 32'(ov_dout), 32'h8000);
    check("t2_valid_min", 32'(o_dout_valid), 32'd1);
    tick;
    check("t2_drained", 32'(o_dout_valid), 32'd0);

    // Truncation versus rounding of small values.
    iv_din = 24'hFFFFF8; i_din_valid = 1'b1;
    tick;
    check("t3_sat_a", 32'(o_sat), 32'd0);
    iv_din = 24'h000018;
    tick;
    i_din_valid = 1'b0;
    tick;
    check("t3_neg8", 32'(ov_dout), 32'(exp_neg8));
    tick;
    check("t3_pos24", 32'(ov_dout), 32'(exp_pos24));
    tick;

    // Overflow: 10 samples into a stalled 8-deep FIFO.
    i_dout_ready = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      iv_din = 24'(j << 4); i_din_valid = 1'b1;
      tick;
    end
    i_din_valid = 1'b0;
    tick;
    check("t4_level", 32'(ov_level), 32'd8);
    check("t4_ovf", 32'(o_overflow), 32'd1);
    check("t4_drop", 32'(ov_drop_cnt), 32'd2);
    i_dout_ready = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      check($sformatf("t4_order%0d", j), 32'({o_dout_valid, ov_dout}), 32'({1'b1, 16'(j)}));
      tick;
    end
    check("t4_empty", 32'(o_dout_valid), 32'd0);

    // Full FIFO with simultaneous pop and write: no drops.
    i_dout_ready = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      iv_din = 24'((8'h30 + j) << 4); i_din_valid = 1'b1;
      tick;
    end
    check("t5_full", 32'(ov_level), 32'd8);
    i_dout_ready = 1'b1;
    for (int m = 1; m <= 4; m++) begin
      iv_din = 24'((8'h39 + m) << 4);
      tick;
      check($sformatf("t5_level%0d", m), 32'(ov_level), 32'd8);
      check($sformatf("t5_head%0d", m), 32'(ov_dout), 32'(8'h31 + m));
    end
    check("t5_nodrop", 32'(ov_drop_cnt), 32'd2);
    i_din_valid = 1'b0;
    repeat (12) tick;
    check("t5_drained", 32'(ov_level), 32'd0);
    i_clr_ovf = 1'b1;
    tick;
    i_clr_ovf = 1'b0;
    check("t5_clr_ovf", 32'(o_overflow), 32'd0);
    check("t5_clr_cnt", 32'(ov_drop_cnt), 32'd0);

    // Clear and drop in the same cycle: the drop wins.
    i_dout_ready = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      iv_din = 24'((8'h40 + j) << 4); i_din_valid = 1'b1;
      tick;
    end
    i_din_valid = 1'b0; i_clr_ovf = 1'b1;
    tick;
    i_clr_ovf = 1'b0;
    check("t5b_ovf", 32'(o_overflow), 32'd1);
    check("t5b_cnt", 32'(ov_drop_cnt), 32'd1);

    // Enable low: everything freezes, ready ignored, input not sampled.
    i_en = 1'b0; i_dout_ready = 1'b1; i_din_valid = 1'b1; iv_din = 24'h7FFFFF;
    repeat (3) tick;
    check("en_level", 32'(ov_level), 32'd8);
    check("en_head", 32'(ov_dout), 32'h0041);
    check("en_cnt", 32'(ov_drop_cnt), 32'd1);
    i_en = 1'b1; i_din_valid = 1'b0;
    repeat (3) tick;
    check("pre_rst_level", 32'(ov_level), 32'd5);

    // Async reset with 5 buffered samples, no clock edge needed.
    i_dout_ready = 1'b0;
    iv_din = 24'h000500; i_din_valid = 1'b1;
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_dout", 32'(ov_dout), 32'd0);
    check("arst_valid", 32'(o_dout_valid), 32'd0);
    check("arst_level", 32'(ov_level), 32'd0);
    check("arst_ovf", 32'(o_overflow), 32'd0);
    check("arst_cnt", 32'(ov_drop_cnt), 32'd0);
    i_din_valid = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1; i_dout_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      tick;
      check($sformatf("arst_stale%0d", m), 32'(o_dout_valid), 32'd0);
    end
    iv_din = 24'(8'h50 << 4); i_din_valid = 1'b1;
    tick;
    i_din_valid = 1'b0;
    tick;
    tick;
    check("arst_fresh", 32'({o_dout_valid, ov_dout}), 32'({1'b1, 16'h0050}));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
